// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the ResNet-18 stem max-pool.
// Float32 encodings, row classes and a counter-width function.
package cnn_pkg;

  localparam logic [31:0] FP32_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ROW_FIRST,
    ROW_EVEN,
    ROW_ODD
  } row_cls_e;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_maxpool_3x3_s2_if.sv
// Pixel stream bundle between the stem ReLU, the pool and layer1.
// master drives pixels in; slave (the pool) drives pooled pixels out.
interface cnn_maxpool_3x3_s2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output valid_in, pxl_in,
    input  pxl_out, valid_out, frame_done
  );

  modport slave (
    input  valid_in, pxl_in,
    output pxl_out, valid_out, frame_done
  );
endinterface

// File: rtl/cnn_fp32_max.sv
// Combinational 2-input float32 max, bit-pattern ordered.
// CNN_MAXPOOL_UNSIGNED_CMP_EN: plain unsigned compare (inputs >= 0).
module cnn_fp32_max #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

`ifdef CNN_MAXPOOL_UNSIGNED_CMP_EN
  // non-negative data: whole-word unsigned compare
  always_comb begin
    y = (a > b) ? a : b;
  end
`else
  logic sa;
  logic sb;

  assign sa = a[DATA_WIDTH-1];
  assign sb = b[DATA_WIDTH-1];

  // sign decides first; equal signs compare magnitudes
  always_comb begin
    y = a;
    unique case (1'b1)
      sa != sb:  y = sa ? b : a;
      !sa && !sb: y = (a > b) ? a : b;
      sa && sb:  y = (a < b) ? a : b;
      default:   y = a;
    endcase
  end
`endif

endmodule

// File: rtl/cnn_maxpool_3x3_s2.sv
// Streaming 3x3/s2/p1 max-pool for the ResNet-18 stem.
// Optional macro: CNN_MAXPOOL_UNSIGNED_CMP_EN (post-ReLU, PAD = +0).
module cnn_maxpool_3x3_s2
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 1024,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int CHANNEL_NUM  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  cnn_maxpool_3x3_s2_if.slave     bus
);

  localparam int HALF_W = IMAGE_WIDTH / 2;
  localparam int COL_W  = cw(IMAGE_WIDTH);
  localparam int ROW_W  = cw(IMAGE_HEIGHT);
  localparam int CH_W   = cw(CHANNEL_NUM);
  localparam int J_W    = cw(HALF_W);

`ifdef CNN_MAXPOOL_UNSIGNED_CMP_EN
  localparam logic [DATA_WIDTH-1:0] PAD =
    DATA_WIDTH'(FP32_POS_ZERO);
`else
  localparam logic [DATA_WIDTH-1:0] PAD =
    DATA_WIDTH'(FP32_NEG_INF);
`endif

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CH_W-1:0]  ch;
  logic             col_last;
  logic             row_last;
  logic             ch_last;

  logic [DATA_WIDTH-1:0] even_reg;
  logic [DATA_WIDTH-1:0] carry;
  logic [DATA_WIDTH-1:0] carry_eff;
  logic [DATA_WIDTH-1:0] hm_0;
  logic [DATA_WIDTH-1:0] hm;
  row_cls_e              row_cls;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_hm;
  logic [J_W-1:0]        s1_j;
  row_cls_e              s1_cls;
  logic                  s1_last;

  logic [DATA_WIDTH-1:0] line_buf [HALF_W];
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] buf_wr;
  logic [DATA_WIDTH-1:0] vm;
  logic                  emit;

  assign col_last = col == COL_W'(IMAGE_WIDTH - 1);
  assign row_last = row == ROW_W'(IMAGE_HEIGHT - 1);
  assign ch_last  = ch == CH_W'(CHANNEL_NUM - 1);

  // raster position: col -> row -> channel, on accepted pixels
  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (bus.valid_in) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
          ch  <= ch_last ? '0 : ch + CH_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // left edge of each row sees the pad value
  assign carry_eff = (col == COL_W'(1)) ? PAD : carry;

  always_comb begin
    row_cls = ROW_EVEN;
    unique case (1'b1)
      row == '0: row_cls = ROW_FIRST;
      row != '0 && row[0]: row_cls = ROW_ODD;
      default: row_cls = ROW_EVEN;
    endcase
  end

  cnn_fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_h0 (
    .a (carry_eff),
    .b (even_reg),
    .y (hm_0)
  );

  cnn_fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_h1 (
    .a (hm_0),
    .b (bus.pxl_in),
    .y (hm)
  );

  // stage 1 valid: one horizontal result per odd column
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.valid_in & col[0];
    end
  end

  // stage 1 data: horizontal window and its position tags
  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      if (!col[0]) begin
        even_reg <= bus.pxl_in;
      end else begin
        carry   <= bus.pxl_in;
        s1_hm   <= hm;
        s1_j    <= J_W'(col >> 1);
        s1_cls  <= row_cls;
        s1_last <= col_last & row_last & ch_last;
      end
    end
  end

  assign buf_rd = line_buf[s1_j];

  cnn_fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_v (
    .a (buf_rd),
    .b (s1_hm),
    .y (vm)
  );

  assign emit = s1_valid && (s1_cls == ROW_ODD);

  always_comb begin
    buf_wr = s1_hm;
    unique case (s1_cls)
      ROW_EVEN: buf_wr = vm;
      default:  buf_wr = s1_hm;
    endcase
  end

  // line buffer: read-before-write of the same column pair
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      line_buf[s1_j] <= buf_wr;
    end
  end

  // stage 2: registered pooled pixel and frame-end flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.pxl_out    <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.valid_out  <= emit;
      bus.frame_done <= emit & s1_last;
      if (emit) begin
        bus.pxl_out <= vm;
      end
    end
  end

endmodule

// File: tb/tb_cnn_maxpool_3x3_s2.sv
// Directed bench for cnn_maxpool_3x3_s2 on a 4x4x2 geometry.
// Scoreboard queue holds value, frame flag and due cycle per output.
module tb_cnn_maxpool_3x3_s2;

  localparam int W = 4;
  localparam int H = 4;
  localparam int C = 2;

  typedef logic [31:0] plane_t [16];
  typedef logic [31:0] quad_t [4];
  typedef struct {
    logic [31:0] data;
    logic        fd;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  plane_t fv;
  plane_t p_up;
  plane_t p_dn;
  plane_t p_neg;
  plane_t p_sz;
  plane_t p_zero;
  quad_t  e_up;
  quad_t  e_dn;
  quad_t  e_neg;
  quad_t  e_sz;
  quad_t  e_zero;

  cnn_maxpool_3x3_s2_if #(.DATA_WIDTH(32)) bus ();

  cnn_maxpool_3x3_s2 #(
    .DATA_WIDTH   (32),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .CHANNEL_NUM  (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_out", {31'b0, bus.valid_out}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pxl_out", bus.pxl_out, e.data);
          chk("frame_done", {31'b0, bus.frame_done}, {31'b0, e.fd});
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("idle_frame_done", {31'b0, bus.frame_done}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_pxl_out", bus.pxl_out, 32'd0);
    chk("rst_valid_out", {31'b0, bus.valid_out}, 32'd0);
    chk("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic send_plane(input plane_t pl, input quad_t ex,
                            input bit fd_last, input int gap_max,
                            input int npix, input bit push);
    int   k;
    int   g;
    exp_t e;
    k = 0;
    for (int i = 0; i < npix; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        repeat (g) begin
          @(negedge clk);
          bus.valid_in = 1'b0;
        end
      end
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.pxl_in = pl[i];
      if (push && ((i / W) % 2 == 1) && ((i % W) % 2 == 1)) begin
        e.data = ex[k];
        e.fd = fd_last && (k == 3);
        e.due = cyc + 2;
        sb.push_back(e);
        k++;
      end
    end
  endtask

  initial begin
    fv = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
           32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
           32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
           32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000};
    for (int i = 0; i < 16; i++) begin
      p_up[i] = fv[i];
      p_dn[i] = fv[15 - i];
      p_neg[i] = 32'hBF80_0000;
      p_sz[i] = 32'h8000_0000;
      p_zero[i] = 32'h0000_0000;
    end
    p_neg[10] = 32'hBF00_0000;
    p_sz[15] = 32'h0000_0000;
    e_up = '{fv[5], fv[7], fv[13], fv[15]};
    e_dn = '{fv[15], fv[14], fv[11], fv[10]};
    e_neg = '{32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF00_0000};
    e_sz = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    e_zero = '{32'h0, 32'h0, 32'h0, 32'h0};

    bus.valid_in = 1'b0;
    bus.pxl_in = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    chk("init_pxl_out", bus.pxl_out, 32'd0);
    chk("init_valid_out", {31'b0, bus.valid_out}, 32'd0);
    chk("init_frame_done", {31'b0, bus.frame_done}, 32'd0);

    send_plane(p_up, e_up, 1'b0, 0, 16, 1'b1);
    idle(4);

`ifndef CNN_MAXPOOL_UNSIGNED_CMP_EN
    do_reset();
    send_plane(p_neg, e_neg, 1'b0, 0, 16, 1'b1);
    idle(4);
    do_reset();
    send_plane(p_sz, e_sz, 1'b0, 0, 16, 1'b1);
    idle(4);
`endif

    do_reset();
    send_plane(p_up, e_up, 1'b0, 5, 16, 1'b1);
    idle(4);

    do_reset();
    send_plane(p_up, e_up, 1'b0, 0, 16, 1'b1);
    send_plane(p_dn, e_dn, 1'b1, 0, 16, 1'b1);
    idle(4);

    do_reset();
    send_plane(p_up, e_up, 1'b0, 0, 7, 1'b1);
    do_reset();
    send_plane(p_up, e_up, 1'b0, 0, 6, 1'b0);
    do_reset();
    send_plane(p_up, e_up, 1'b0, 0, 16, 1'b1);
    idle(4);

    do_reset();
    send_plane(p_up, e_up, 1'b0, 0, 16, 1'b1);
    send_plane(p_zero, e_zero, 1'b1, 0, 16, 1'b1);
    idle(2);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
